// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller.
// Accepts resolved control transfers from execute and compares each with the
// fetch prediction. On an aligned mispredict it issues a valid/ready redirect
// to fetch, then holds flush/stall for FLUSH_CYCLES cycles. A taken transfer to
// a target that is not 4-byte aligned raises a one-cycle misalign pulse and
// never redirects. Saturating branch and mispredict counters are kept.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   br_valid_in / br_ready_out      resolution handshake (ready only in IDLE)
//   br_taken_in, br_pred_taken_in   resolved and predicted outcome
//   br_pc_in, br_target_in          branch PC and resolved taken target
//   redir_valid_out / redir_ready_in, redir_pc_out   redirect handshake to fetch
//   flush_out, stall_out            pipeline kill / freeze
//   misalign_out                    one-cycle misaligned-target pulse
//   branch_cnt_out, mispredict_cnt_out   saturating statistics
module branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid_in,
  output logic             br_ready_out,
  input  logic             br_taken_in,
  input  logic             br_pred_taken_in,
  input  logic [XLEN-1:0]  br_pc_in,
  input  logic [XLEN-1:0]  br_target_in,
  output logic             redir_valid_out,
  input  logic             redir_ready_in,
  output logic [XLEN-1:0]  redir_pc_out,
  output logic             flush_out,
  output logic             stall_out,
  output logic             misalign_out,
  output logic [CNT_W-1:0] branch_cnt_out,
  output logic [CNT_W-1:0] mispredict_cnt_out
);

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FCW-1:0]   r_flush_cnt;
  logic [FCW-1:0]   w_flush_cnt_nxt;
  logic             r_redir_valid;
  logic             r_flush;
  logic             r_stall;
  logic             r_misalign;
  logic [XLEN-1:0]  r_redir_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  logic             w_accept;
  logic             w_misalign;
  logic             w_mispredict;
  logic [XLEN-1:0]  w_target;

  // Resolution decode; misalign wins over mispredict
  assign br_ready_out = (r_state == S_IDLE);
  assign w_accept     = br_valid_in & br_ready_out;
  assign w_misalign   = w_accept & br_taken_in & (br_target_in[1:0] != 2'b00);
  assign w_mispredict = w_accept & (br_taken_in ^ br_pred_taken_in) & ~w_misalign;
  assign w_target     = br_taken_in ? br_target_in : (br_pc_in + XLEN'(4));

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_mispredict) begin
          w_state_nxt = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        if (redir_ready_in) begin
          if (FLUSH_CYCLES > 0) begin
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = FCW'(FLUSH_CYCLES);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        // Count holds the remaining FLUSH cycles including the current one
        if (r_flush_cnt <= FCW'(1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, registered output decodes, redirect PC and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_flush_cnt      <= '0;
      r_redir_valid    <= 1'b0;
      r_flush          <= 1'b0;
      r_stall          <= 1'b0;
      r_misalign       <= 1'b0;
      r_redir_pc       <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_redir_valid <= (w_state_nxt == S_REDIRECT);
      r_flush       <= (w_state_nxt != S_IDLE);
      r_stall       <= (w_state_nxt != S_IDLE);
      r_misalign    <= w_misalign;
      if (w_mispredict) begin
        r_redir_pc <= w_target;
      end
      if (w_accept && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_mispredict && (r_mispredict_cnt != '1)) begin
        r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
      end
    end
  end

  assign redir_valid_out    = r_redir_valid;
  assign redir_pc_out       = r_redir_pc;
  assign flush_out          = r_flush;
  assign stall_out          = r_stall;
  assign misalign_out       = r_misalign;
  assign branch_cnt_out     = r_branch_cnt;
  assign mispredict_cnt_out = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl. A transaction-level model
// derives expected redirect PC, handshake/flush timing and counter values.
// A second instance (CNT_W = 4, FLUSH_CYCLES = 0) covers saturation and the
// zero-length flush case.
module tb_branch_redirect_ctrl;

  localparam int unsigned FC   = 2;
  localparam int          CMAX = 65535;
  localparam int          SMAX = 15;

  logic        clk;
  logic        reset;

  logic        br_valid_in, br_ready_out, br_taken_in, br_pred_taken_in;
  logic [31:0] br_pc_in, br_target_in, redir_pc_out;
  logic        redir_valid_out, redir_ready_in, flush_out, stall_out, misalign_out;
  logic [15:0] branch_cnt_out, mispredict_cnt_out;

  logic        s_valid, s_ready, s_taken, s_pred;
  logic [31:0] s_pc, s_target, s_redir_pc;
  logic        s_redir_valid, s_redir_ready, s_flush, s_stall, s_misalign;
  logic [3:0]  s_branch_cnt, s_mispredict_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int m_branch = 0;
  int m_mispred = 0;

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .br_valid_in(br_valid_in), .br_ready_out(br_ready_out),
    .br_taken_in(br_taken_in), .br_pred_taken_in(br_pred_taken_in),
    .br_pc_in(br_pc_in), .br_target_in(br_target_in),
    .redir_valid_out(redir_valid_out), .redir_ready_in(redir_ready_in),
    .redir_pc_out(redir_pc_out), .flush_out(flush_out), .stall_out(stall_out),
    .misalign_out(misalign_out), .branch_cnt_out(branch_cnt_out),
    .mispredict_cnt_out(mispredict_cnt_out)
  );

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .br_valid_in(s_valid), .br_ready_out(s_ready),
    .br_taken_in(s_taken), .br_pred_taken_in(s_pred),
    .br_pc_in(s_pc), .br_target_in(s_target),
    .redir_valid_out(s_redir_valid), .redir_ready_in(s_redir_ready),
    .redir_pc_out(s_redir_pc), .flush_out(s_flush), .stall_out(s_stall),
    .misalign_out(s_misalign), .branch_cnt_out(s_branch_cnt),
    .mispredict_cnt_out(s_mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters();
    check("branch_cnt", 64'(branch_cnt_out), 64'(m_branch));
    check("mispredict_cnt", 64'(mispredict_cnt_out), 64'(m_mispred));
  endtask

  // One resolved transfer; starts and ends 1 time unit after a rising edge in IDLE
  task automatic send(input logic tk, input logic pd, input logic [31:0] pc,
                      input logic [31:0] tgt, input int dly);
    logic        mis_al;
    logic        mp;
    logic [31:0] exp_pc;
    logic [31:0] rnd;
    mis_al = tk && (tgt[1:0] != 2'b00);
    mp     = (tk != pd) && !mis_al;
    exp_pc = tk ? tgt : (pc + 32'd4);
    check("ready_before_accept", 64'(br_ready_out), 64'd1);
    br_valid_in      = 1'b1;
    br_taken_in      = tk;
    br_pred_taken_in = pd;
    br_pc_in         = pc;
    br_target_in     = tgt;
    rnd              = $urandom;
    redir_ready_in   = rnd[0];
    tick();
    br_valid_in = 1'b0;
    if (m_branch < CMAX) m_branch++;
    if (mp && m_mispred < CMAX) m_mispred++;
    if (mis_al) begin
      check("misalign_pulse", 64'(misalign_out), 64'd1);
      check("misalign_no_redir", 64'(redir_valid_out), 64'd0);
      check("misalign_no_flush", 64'(flush_out), 64'd0);
      check("misalign_ready", 64'(br_ready_out), 64'd1);
      tick();
      check("misalign_one_cycle", 64'(misalign_out), 64'd0);
    end else if (mp) begin
      for (int k = 0; k <= dly; k++) begin
        check("redir_valid", 64'(redir_valid_out), 64'd1);
        check("redir_pc", 64'(redir_pc_out), 64'(exp_pc));
        check("redir_flush", 64'(flush_out), 64'd1);
        check("redir_stall", 64'(stall_out), 64'd1);
        check("redir_not_ready", 64'(br_ready_out), 64'd0);
        rnd            = $urandom;
        redir_ready_in = (k == dly);
        br_valid_in    = rnd[0];
        br_taken_in    = rnd[1];
        br_pred_taken_in = ~rnd[1];
        tick();
      end
      for (int f = 0; f < int'(FC); f++) begin
        check("flush_hold", 64'(flush_out), 64'd1);
        check("flush_stall", 64'(stall_out), 64'd1);
        check("flush_no_redir", 64'(redir_valid_out), 64'd0);
        check("flush_not_ready", 64'(br_ready_out), 64'd0);
        rnd            = $urandom;
        br_valid_in    = rnd[0];
        redir_ready_in = rnd[1];
        tick();
      end
      br_valid_in    = 1'b0;
      redir_ready_in = 1'b0;
      check("post_flush_ready", 64'(br_ready_out), 64'd1);
      check("post_flush_flush", 64'(flush_out), 64'd0);
      check("post_flush_stall", 64'(stall_out), 64'd0);
      check("post_flush_redir", 64'(redir_valid_out), 64'd0);
    end else begin
      check("correct_no_redir", 64'(redir_valid_out), 64'd0);
      check("correct_no_flush", 64'(flush_out), 64'd0);
      check("correct_no_misalign", 64'(misalign_out), 64'd0);
      check("correct_ready", 64'(br_ready_out), 64'd1);
    end
    check_counters();
  endtask

  initial begin
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic [31:0] r_ctl;

    reset = 1'b1;
    br_valid_in = 1'b1; br_taken_in = 1'b1; br_pred_taken_in = 1'b0;
    br_pc_in = 32'h0000_1000; br_target_in = 32'h0000_2000; redir_ready_in = 1'b0;
    s_valid = 1'b1; s_taken = 1'b1; s_pred = 1'b0;
    s_pc = 32'h0; s_target = 32'h100; s_redir_ready = 1'b0;

    // Reset held two cycles with a valid resolution offered
    tick();
    tick();
    check("rst_ready", 64'(br_ready_out), 64'd1);
    check("rst_redir_valid", 64'(redir_valid_out), 64'd0);
    check("rst_redir_pc", 64'(redir_pc_out), 64'd0);
    check("rst_flush", 64'(flush_out), 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);
    check("rst_misalign", 64'(misalign_out), 64'd0);
    check_counters();
    check("rst_sat_cnt", 64'(s_mispredict_cnt), 64'd0);
    br_valid_in = 1'b0;
    s_valid     = 1'b0;
    reset       = 1'b0;
    tick();
    check("post_rst_ready", 64'(br_ready_out), 64'd1);
    check_counters();

    // Correct predictions back to back
    for (int i = 0; i < 5; i++) begin
      r_pc = $urandom;
      r_tgt = $urandom;
      r_ctl = $urandom;
      send(r_ctl[0], r_ctl[0], {r_pc[31:2], 2'b00}, {r_tgt[31:2], 2'b00}, 0);
    end
    check("stream_branch_cnt", 64'(branch_cnt_out), 64'd5);
    check("stream_mispredict_cnt", 64'(mispredict_cnt_out), 64'd0);

    // Taken mispredict with fetch stalling three cycles
    send(1'b1, 1'b0, 32'h0000_1000, 32'h0000_2040, 3);
    check("taken_mp_cnt", 64'(mispredict_cnt_out), 64'd1);

    // Not-taken mispredict whose fall-through wraps to zero
    send(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_8000, 0);

    // Misaligned taken target: pulse only
    send(1'b1, 1'b0, 32'h0000_1000, 32'h0000_2042, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      r_pc  = $urandom;
      r_tgt = $urandom;
      r_ctl = $urandom;
      if (r_ctl[4:2] != 3'd0) r_tgt[1:0] = 2'b00;
      send(r_ctl[0], r_ctl[1], {r_pc[31:2], 2'b00}, r_tgt, int'(r_ctl[6:5]));
    end

    // Reset during FLUSH aborts the sequence and clears counters
    br_valid_in = 1'b1; br_taken_in = 1'b0; br_pred_taken_in = 1'b1;
    br_pc_in = 32'h0000_4000; br_target_in = 32'h0000_5000; redir_ready_in = 1'b1;
    tick();
    br_valid_in = 1'b0;
    tick();
    check("pre_rst_flush", 64'(flush_out), 64'd1);
    check("pre_rst_redir", 64'(redir_valid_out), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    redir_ready_in = 1'b0;
    m_branch  = 0;
    m_mispred = 0;
    check("midrst_flush", 64'(flush_out), 64'd0);
    check("midrst_stall", 64'(stall_out), 64'd0);
    check("midrst_redir", 64'(redir_valid_out), 64'd0);
    check("midrst_ready", 64'(br_ready_out), 64'd1);
    check("midrst_redir_pc", 64'(redir_pc_out), 64'd0);
    check_counters();
    tick();
    check("midrst_stays_idle", 64'(br_ready_out), 64'd1);
    check_counters();

    // Saturation on the narrow-counter instance with zero flush cycles
    for (int i = 1; i <= 20; i++) begin
      r_tgt = $urandom;
      s_valid = 1'b1; s_taken = 1'b1; s_pred = 1'b0;
      s_pc = 32'h0000_0100; s_target = {r_tgt[31:2], 2'b00}; s_redir_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      check("sat_redir_valid", 64'(s_redir_valid), 64'd1);
      check("sat_redir_pc", 64'(s_redir_pc), 64'({r_tgt[31:2], 2'b00}));
      check("sat_flush", 64'(s_flush), 64'd1);
      tick();
      check("sat_ready_back", 64'(s_ready), 64'd1);
      check("sat_flush_done", 64'(s_flush), 64'd0);
      check("sat_mispredict_cnt", 64'(s_mispredict_cnt), 64'((i < SMAX) ? i : SMAX));
      check("sat_branch_cnt", 64'(s_branch_cnt), 64'((i < SMAX) ? i : SMAX));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences PC redirection after the execute-stage branch unit resolves a conditional branch or jump.
- Compares the resolved outcome with the fetch-stage prediction and, on mismatch, drives a redirect handshake to fetch.
- Then holds a pipeline flush for a programmable number of cycles.
- Keeps saturating branch and mispredict statistics counters for performance monitoring.

Parameters:
- XLEN, 32, width of PC/target values.
- FLUSH_CYCLES, 2, flush-hold cycles after redirect accepted (0 allowed).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- br_valid_in  in  1  execute stage presents a resolved control transfer
- br_ready_out  out  1  controller accepts a resolution this cycle
- br_taken_in  in  1  resolved outcome: 1 = taken / jump
- br_pred_taken_in  in  1  outcome predicted by fetch for this instruction
- br_pc_in  in  XLEN  PC of the branch instruction
- br_target_in  in  XLEN  resolved taken target (pc+imm or rs1+imm, computed upstream)
- redir_valid_out  out  1  redirect request to fetch
- redir_ready_in  in  1  fetch accepts redirect
- redir_pc_out  out  XLEN  new fetch PC
- flush_out  out  1  kill younger instructions in IF/ID
- stall_out  out  1  freeze execute and older stages
- misalign_out  out  1  one-cycle pulse: taken target not 4-byte aligned
- branch_cnt_out  out  CNT_W  resolutions accepted
- mispredict_cnt_out  out  CNT_W  mispredictions redirected

Behaviour:
- Reset values:
  - State = IDLE.
  - All 1-bit outputs 0 except br_ready_out = 1.
  - redir_pc_out = 0.
  - Both counters = 0.
  - Reset mid-operation aborts any redirect or flush immediately; the pending request is dropped.
- Accept = br_valid_in & br_ready_out. br_ready_out = 1 only in IDLE (combinational from state). The producer holds all br_* inputs stable until accepted.
- On accept:
  - branch_cnt increments, saturating at all-ones.
  - mispredict = br_taken_in XOR br_pred_taken_in.
  - Computed target = br_taken_in ? br_target_in : br_pc_in + 4, modulo 2^XLEN, so wrap-around is allowed.
- Misalign: accept with br_taken_in = 1 and br_target_in[1:0] != 0:
  - misalign_out = 1 in the next cycle, for exactly one cycle.
  - No redirect; mispredict_cnt is unchanged; state stays IDLE.
  - Misalign takes priority over mispredict.
- Correct prediction: no further action; remain IDLE. Back-to-back accepts are allowed every cycle.
- Mispredict (aligned): latch the computed target into redir_pc_out; next state REDIRECT; mispredict_cnt increments, saturating.
- FSM:
  - IDLE: as above.
  - REDIRECT: redir_valid_out = 1, flush_out = 1, stall_out = 1. redir_pc_out is held stable while waiting. When redir_ready_in = 1 the handshake completes that cycle. Next state is FLUSH if FLUSH_CYCLES > 0, else IDLE.
  - FLUSH: flush_out = 1, stall_out = 1, redir_valid_out = 0. A down-counter is loaded with FLUSH_CYCLES on handshake. Leave to IDLE after exactly FLUSH_CYCLES cycles in FLUSH.
- Latency:
  - Mispredict accept at cycle N → redir_valid_out = 1 at N+1.
  - With redir_ready_in already high: handshake at N+1, flush_out high at N+1 through N+1+FLUSH_CYCLES.
  - br_ready_out returns at N+2+FLUSH_CYCLES.
- Outputs are registered state decodes, except br_ready_out (state decode, glitch-free).
- br_valid_in while not ready is ignored and not counted.
- redir_ready_in outside REDIRECT has no effect.
- Counters are never cleared except by reset.

Test Plan:
- Reset: hold reset 2 cycles with br_valid_in = 1 → all outputs at reset values, counters 0, nothing accepted; release → br_ready_out = 1.
- Correct prediction stream: 5 consecutive accepts with taken = pred → branch_cnt = 5, mispredict_cnt = 0, redir_valid_out never 1, flush_out never 1.
- Taken mispredict: pc = 0x0000_1000, target = 0x0000_2040, taken = 1, pred = 0, redir_ready_in stalled 3 cycles → redir_valid_out high 4 cycles with redir_pc_out = 0x0000_2040 stable; flush high for 4 + FLUSH_CYCLES(2) cycles; br_ready_out low throughout; mispredict_cnt = 1.
- Not-taken mispredict at wrap: pc = 0xFFFF_FFFC, taken = 0, pred = 1 → redir_pc_out = 0x0000_0000.
- Misaligned target 0x0000_2042 with taken = 1 → misalign_out pulses 1 cycle; no redirect; mispredict_cnt unchanged; branch_cnt increments.
- Reset asserted during FLUSH → next cycle IDLE, flush_out = 0, counters 0. Separately, with CNT_W = 4, 20 mispredicts → mispredict_cnt saturates at 15.
